// File: rtl/cond_flag_unit_if.sv
// Controller-to-conditional-stage bundle: ungated instruction strobes in, squash-gated strobes out.
interface cond_flag_unit_if;
  logic       ctrl_valid;
  logic [3:0] Cond;
  logic [3:0] ALUFlags;
  logic [1:0] FlagW;
  logic       PCSrc;
  logic       RegWrite;
  logic       MemWrite;
  logic       BX_ctrl;
  logic       PCSrcG;
  logic       RegWriteG;
  logic       MemWriteG;
  logic       BXG;

  modport master (
    output ctrl_valid, Cond, ALUFlags, FlagW, PCSrc, RegWrite, MemWrite, BX_ctrl,
    input  PCSrcG, RegWriteG, MemWriteG, BXG
  );

  modport slave (
    input  ctrl_valid, Cond, ALUFlags, FlagW, PCSrc, RegWrite, MemWrite, BX_ctrl,
    output PCSrcG, RegWriteG, MemWriteG, BXG
  );
endinterface

// File: rtl/cond_flag_unit.sv
// Conditional-execution stage: NZCV flag register, condition check and strobe squashing.
// Optional saturating execute/squash statistics counters are enabled with `define COND_STATS_EN.
module cond_flag_unit #(
  parameter logic [3:0] FLAG_RST = 4'b0000,
  parameter int         CNT_W    = 16
) (
  input  logic                 clk,
  input  logic                 RESET,
  cond_flag_unit_if.slave      ctrl,
  output logic                 CondEx,
  output logic [3:0]           Flags,
  output logic                 squash_q,
  output logic [CNT_W-1:0]     exec_cnt,
  output logic [CNT_W-1:0]     squash_cnt
);

  logic flag_n;
  logic flag_z;
  logic flag_c;
  logic flag_v;
  logic ge;
  logic issue;

  assign flag_n = Flags[3];
  assign flag_z = Flags[2];
  assign flag_c = Flags[1];
  assign flag_v = Flags[0];
  assign ge     = (flag_n == flag_v);

  // Condition is always judged against the flags held before this instruction's own update.
  always_comb begin
    CondEx = 1'b0;
    case (ctrl.Cond)
      4'b0000: CondEx = flag_z;
      4'b0001: CondEx = !flag_z;
      4'b0010: CondEx = flag_c;
      4'b0011: CondEx = !flag_c;
      4'b0100: CondEx = flag_n;
      4'b0101: CondEx = !flag_n;
      4'b0110: CondEx = flag_v;
      4'b0111: CondEx = !flag_v;
      4'b1000: CondEx = flag_c && !flag_z;
      4'b1001: CondEx = !flag_c || flag_z;
      4'b1010: CondEx = ge;
      4'b1011: CondEx = !ge;
      4'b1100: CondEx = !flag_z && ge;
      4'b1101: CondEx = flag_z || !ge;
      4'b1110: CondEx = 1'b1;
      default: CondEx = 1'b0;
    endcase
  end

  assign issue = ctrl.ctrl_valid && CondEx;

  assign ctrl.PCSrcG    = ctrl.PCSrc    && issue;
  assign ctrl.RegWriteG = ctrl.RegWrite && issue;
  assign ctrl.MemWriteG = ctrl.MemWrite && issue;
  assign ctrl.BXG       = ctrl.BX_ctrl  && issue;

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      Flags <= FLAG_RST;
    end else if (issue) begin
      if (ctrl.FlagW[1]) Flags[3:2] <= ctrl.ALUFlags[3:2];
      if (ctrl.FlagW[0]) Flags[1:0] <= ctrl.ALUFlags[1:0];
    end
  end

  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      squash_q <= 1'b0;
    end else if (ctrl.ctrl_valid) begin
      squash_q <= !CondEx;
    end
  end

`ifdef COND_STATS_EN
  // Counters stick at all-ones so a long run never reports a misleadingly small count.
  always_ff @(posedge clk or negedge RESET) begin
    if (!RESET) begin
      exec_cnt   <= '0;
      squash_cnt <= '0;
    end else if (ctrl.ctrl_valid) begin
      if (CondEx && (exec_cnt != '1))
        exec_cnt <= exec_cnt + CNT_W'(1);
      if (!CondEx && (squash_cnt != '1))
        squash_cnt <= squash_cnt + CNT_W'(1);
    end
  end
`else
  assign exec_cnt   = '0;
  assign squash_cnt = '0;
`endif

endmodule

// File: tb/tb_cond_flag_unit.sv
// Directed bench for cond_flag_unit: vector table, reset/condition sweeps and statistics counters.
module tb_cond_flag_unit;

  logic       clk;
  logic       RESET;
  logic       CondEx;
  logic [3:0] Flags;
  logic       squash_q;
  logic [3:0] exec_cnt;
  logic [3:0] squash_cnt;

  int testCount = 0;
  int failCount = 0;
  int expExec   = 0;
  int expSquash = 0;

  cond_flag_unit_if ifc ();

  cond_flag_unit #(
    .FLAG_RST (4'b0000),
    .CNT_W    (4)
  ) dut (
    .clk        (clk),
    .RESET      (RESET),
    .ctrl       (ifc.slave),
    .CondEx     (CondEx),
    .Flags      (Flags),
    .squash_q   (squash_q),
    .exec_cnt   (exec_cnt),
    .squash_cnt (squash_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  typedef struct {
    logic       cv;
    logic [3:0] cond;
    logic [3:0] alu;
    logic [1:0] flagw;
    logic       pc;
    logic       rw;
    logic       mw;
    logic       bx;
    logic       expCondEx;
    logic [3:0] expGated;
    logic [3:0] expFlags;
    logic       expSquash;
  } vector_t;

  vector_t vectors [15];

  function automatic logic refCond(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'h0: return z;
      4'h1: return ~z;
      4'h2: return cf;
      4'h3: return ~cf;
      4'h4: return n;
      4'h5: return ~n;
      4'h6: return v;
      4'h7: return ~v;
      4'h8: return cf & ~z;
      4'h9: return ~cf | z;
      4'hA: return ~(n ^ v);
      4'hB: return n ^ v;
      4'hC: return ~z & ~(n ^ v);
      4'hD: return z | (n ^ v);
      4'hE: return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  task automatic checkOutput(input string name, input logic [15:0] actual, input logic [15:0] expected);
    testCount++;
    if (actual !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  task automatic driveInputs(input logic cv, input logic [3:0] cond, input logic [3:0] alu,
                             input logic [1:0] flagw, input logic [3:0] strobes);
    ifc.ctrl_valid = cv;
    ifc.Cond       = cond;
    ifc.ALUFlags   = alu;
    ifc.FlagW      = flagw;
    {ifc.PCSrc, ifc.RegWrite, ifc.MemWrite, ifc.BX_ctrl} = strobes;
  endtask

  task automatic countStats(input logic cv, input logic passed);
    if (cv) begin
      if (passed) expExec   = (expExec   < 15) ? expExec + 1   : 15;
      else        expSquash = (expSquash < 15) ? expSquash + 1 : 15;
    end
  endtask

  task automatic checkStats(input string tag);
`ifdef COND_STATS_EN
    checkOutput({tag, " exec_cnt"},   16'(exec_cnt),   16'(expExec));
    checkOutput({tag, " squash_cnt"}, 16'(squash_cnt), 16'(expSquash));
`else
    checkOutput({tag, " exec_cnt"},   16'(exec_cnt),   16'h0);
    checkOutput({tag, " squash_cnt"}, 16'(squash_cnt), 16'h0);
`endif
  endtask

  task automatic applyStimulus(input int idx, input vector_t v);
    @(negedge clk);
    driveInputs(v.cv, v.cond, v.alu, v.flagw, {v.pc, v.rw, v.mw, v.bx});
    #1;
    checkOutput($sformatf("v%0d CondEx", idx), 16'(CondEx), 16'(v.expCondEx));
    checkOutput($sformatf("v%0d gated", idx),
                16'({ifc.PCSrcG, ifc.RegWriteG, ifc.MemWriteG, ifc.BXG}), 16'(v.expGated));
    @(posedge clk);
    #1;
    checkOutput($sformatf("v%0d Flags", idx), 16'(Flags), 16'(v.expFlags));
    checkOutput($sformatf("v%0d squash_q", idx), 16'(squash_q), 16'(v.expSquash));
    countStats(v.cv, v.expCondEx);
  endtask

  task automatic pulseReset();
    @(negedge clk);
    driveInputs(1'b0, 4'hE, 4'h0, 2'b00, 4'h0);
    RESET = 1'b0;
    @(negedge clk);
    RESET = 1'b1;
    expExec   = 0;
    expSquash = 0;
  endtask

  initial begin
    // Fields: cv cond alu flagw pc rw mw bx | CondEx gated{pc,rw,mw,bx} Flags squash_q
    vectors[0]  = '{1'b1, 4'b1110, 4'b0100, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0};
    vectors[1]  = '{1'b1, 4'b0000, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b0100, 1'b0};
    vectors[2]  = '{1'b1, 4'b0001, 4'b1001, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 4'b0000, 4'b0100, 1'b1};
    vectors[3]  = '{1'b0, 4'b1110, 4'b1111, 2'b11, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 4'b0000, 4'b0100, 1'b1};
    vectors[4]  = '{1'b1, 4'b1110, 4'b0000, 2'b11, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 4'b0000, 1'b0};
    vectors[5]  = '{1'b1, 4'b1110, 4'b1111, 2'b10, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1100, 1'b0};
    vectors[6]  = '{1'b1, 4'b1110, 4'b1111, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1111, 1'b0};
    vectors[7]  = '{1'b1, 4'b1111, 4'b0000, 2'b11, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1};
    vectors[8]  = '{1'b1, 4'b1100, 4'b0000, 2'b11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1111, 1'b1};
    vectors[9]  = '{1'b1, 4'b1101, 4'b1001, 2'b11, 1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 4'b1010, 4'b1001, 1'b0};
    vectors[10] = '{1'b1, 4'b1010, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 4'b0100, 4'b1001, 1'b0};
    vectors[11] = '{1'b1, 4'b1011, 4'b0000, 2'b00, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1001, 1'b1};
    vectors[12] = '{1'b1, 4'b1000, 4'b0010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 4'b0000, 4'b1001, 1'b1};
    vectors[13] = '{1'b1, 4'b1001, 4'b0010, 2'b01, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 4'b0000, 4'b1010, 1'b0};
    vectors[14] = '{1'b1, 4'b1000, 4'b0000, 2'b00, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 4'b0001, 4'b1010, 1'b0};

    RESET = 1'b0;
    driveInputs(1'b0, 4'hE, 4'h0, 2'b00, 4'h0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset Flags", 16'(Flags), 16'h0);
    checkOutput("reset squash_q", 16'(squash_q), 16'h0);
    checkStats("reset");
    @(negedge clk);
    RESET = 1'b1;

    for (int i = 0; i < 15; i++) applyStimulus(i, vectors[i]);
    checkStats("table");

    // Asynchronous reset in the middle of a flag-setting instruction.
    @(negedge clk);
    driveInputs(1'b1, 4'hE, 4'hF, 2'b11, 4'h0);
    @(negedge clk);
    driveInputs(1'b1, 4'hF, 4'h0, 2'b11, 4'h0);
    @(negedge clk);
    #1;
    checkOutput("preload Flags", 16'(Flags), 16'hF);
    checkOutput("preload squash_q", 16'(squash_q), 16'h1);
    driveInputs(1'b1, 4'hE, 4'b0101, 2'b11, 4'b0100);
    #1;
    RESET = 1'b0;
    #1;
    checkOutput("async Flags", 16'(Flags), 16'h0);
    checkOutput("async squash_q", 16'(squash_q), 16'h0);
    @(posedge clk);
    #1;
    checkOutput("held reset Flags", 16'(Flags), 16'h0);
    driveInputs(1'b0, 4'hE, 4'b0101, 2'b11, 4'hF);
    #1;
    checkOutput("reset gated", 16'({ifc.PCSrcG, ifc.RegWriteG, ifc.MemWriteG, ifc.BXG}), 16'h0);
    @(negedge clk);
    RESET = 1'b1;
    expExec   = 0;
    expSquash = 0;

    // Sweep every condition code against every flag value.
    for (int f = 0; f < 16; f++) begin
      @(negedge clk);
      driveInputs(1'b1, 4'hE, 4'(f), 2'b11, 4'h0);
      @(negedge clk);
      driveInputs(1'b0, 4'hE, 4'h0, 2'b00, 4'h0);
      #1;
      checkOutput($sformatf("sweep Flags f=%0h", f), 16'(Flags), 16'(f));
      for (int c = 0; c < 16; c++) begin
        ifc.Cond = 4'(c);
        #1;
        checkOutput($sformatf("sweep CondEx c=%0h f=%0h", c, f), 16'(CondEx), 16'(refCond(4'(c), 4'(f))));
      end
    end

    // Statistics: saturation on passes, exact count on squashes, idle cycles ignored.
    pulseReset();
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      driveInputs(1'b1, 4'hE, 4'h0, 2'b00, 4'h0);
      countStats(1'b1, 1'b1);
    end
    @(negedge clk);
    driveInputs(1'b0, 4'hE, 4'h0, 2'b00, 4'h0);
    repeat (3) @(negedge clk);
    checkStats("after passes");
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      driveInputs(1'b1, 4'hF, 4'h0, 2'b00, 4'h0);
      countStats(1'b1, 1'b0);
    end
    @(negedge clk);
    driveInputs(1'b0, 4'hF, 4'h0, 2'b00, 4'h0);
    repeat (3) @(negedge clk);
    checkStats("after squashes");

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
